frame_render_writer: RTL and testbench
======================================

FRAME_RENDER_WRITER -- requirements
Module: frame_render_writer

Interface
REQ-001 SHALL have parameter H_COLS, 100, pixel columns per row.
REQ-002 SHALL have parameter V_ROWS, 600, pixel rows per frame.
REQ-003 SHALL have parameter COLOR_W, 6, bits per pixel.
REQ-004 SHALL have parameter N_PLAT, 5, platform count.
REQ-005 SHALL have parameter HDR_ROWS, 40, header-bar height in rows.
REQ-006 SHALL have parameter ADDR_W, 18, write-address width.
REQ-007 SHALL have port clk  input  1  clock.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port start  input  1  frame-render request pulse.
REQ-010 SHALL have port wr_ready  input  1  memory accepts the write this cycle.
REQ-011 SHALL have port wr_valid  output  1  write request.
REQ-012 SHALL have port wr_addr  output  ADDR_W  pixel address.
REQ-013 SHALL have port wr_data  output  COLOR_W  pixel colour.
REQ-014 SHALL have ports busy and frame_done  output  1 each  render active; one-cycle end-of-frame pulse.
REQ-015 SHALL have ports ball_x  input  7 and ball_y  input  10  ball centre.
REQ-016 SHALL have ports plat_x  input  7*N_PLAT, plat_y  input  10*N_PLAT, plat_w  input  6*N_PLAT  platform centre column, top row and half-width, flattened with platform i at slice i.
REQ-017 SHALL have port over  input  1  game-over flag.
REQ-018 SHALL have port bank  output  1  current frame-buffer bank.

Function
REQ-019 SHALL use the FSM IDLE->LATCH (start)->RUN (1 cycle)->DONE (last pixel accepted)->IDLE (1 cycle).
REQ-020 SHALL snapshot all position inputs and over into shadow registers in LATCH, and SHALL render the whole frame from the shadow copy only (no tearing).
REQ-021 SHALL assert wr_valid throughout RUN and SHALL advance the pixel only on wr_valid && wr_ready; when wr_ready is low, addr and data SHALL stay stable.
REQ-022 SHALL scan col 0..H_COLS-1 inside row 0..V_ROWS-1, with wr_addr = row*H_COLS + col, and wr_data valid in the same cycle as wr_valid.
REQ-023 SHALL assign colour by priority: over => 000011 everywhere; header (row < HDR_ROWS, 5 <= col <= H_COLS-5) => 000000; platform => 001100; ball => 000011; else background 110100.
REQ-024 SHALL treat platform i as hit when plat_y <= row <= plat_y+19 and plat_x-plat_w <= col <= plat_x+plat_w.
REQ-025 SHALL treat the ball as hit when, with dy = |row-ball_y| and dx = |col-ball_x|: dy <= 8 and dx <= 4; or 8 < dy <= 16 and dx <= 3; or 16 < dy <= 20 and dx <= 1.
REQ-026 SHALL compute all differences signed, at least 2 bits wider than the operands, so that off-screen objects clip and never wrap.
REQ-027 SHALL assert busy in LATCH, RUN and DONE, and SHALL pulse frame_done for exactly the DONE cycle.
REQ-028 SHALL ignore start unless in IDLE; a start coincident with DONE SHALL be ignored.

Reset
REQ-029 SHALL on rst, including mid-frame, go to IDLE next cycle with wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, bank=0, counters=0.

Configuration
REQ-030 SHALL, with DOUBLE_BUFFER_EN defined, toggle bank in the DONE cycle and drive wr_addr[ADDR_W-1]=bank, pixel address in the lower bits; ADDR_W-1 bits SHALL cover H_COLS*V_ROWS.
REQ-031 SHALL, without DOUBLE_BUFFER_EN, tie bank to 0 and use the full wr_addr for the pixel address.

Structure
REQ-032 SHALL place colour constants, PLAT_H=20, ball radius breakpoints (8/16/20 with 4/3/1) and the FSM state type in package frame_render_pkg.
REQ-033 SHALL implement the per-platform rectangle test as sub-module sprite_hit, instantiated N_PLAT times via generate.

Verification
REQ-034 SHALL cover: start, wr_ready=1 constantly, over=0 -> 60000 writes, addresses 0..59999 in order, frame_done at cycle 60002.
REQ-035 SHALL cover: ball (50,300), platform 0 (x=20,y=100,w=5) -> addr 300*100+54 is 000011, addr 300*100+55 is 110100, addr 100*100+15 is 001100, addr 120*100+20 is 110100.
REQ-036 SHALL cover: random wr_ready toggling -> write count 60000; addr/data unchanged during every stall cycle.
REQ-037 SHALL cover: ball_x changed mid-frame -> output identical to the frame rendered with the latched value.
REQ-038 SHALL cover: rst asserted at pixel 1234 -> wr_valid=0 next cycle; a following start begins at addr 0.
REQ-039 SHALL cover: DOUBLE_BUFFER_EN, two frames -> frame 2 addresses have MSB=1; over=1 -> all data 000011.

Source files
------------

// File: rtl/frame_render_pkg.sv
// frame_render_pkg: colours, sprite geometry, FSM state type and ball-shape test shared by the frame renderer
package frame_render_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, RUN, DONE} state_t;
  typedef logic signed [11:0] sdiff_t;
  localparam logic [5:0] COL_OVER = 6'b000011;
  localparam logic [5:0] COL_HDR = 6'b000000;
  localparam logic [5:0] COL_PLAT = 6'b001100;
  localparam logic [5:0] COL_BALL = 6'b000011;
  localparam logic [5:0] COL_BG = 6'b110100;
  localparam sdiff_t PLAT_H = 12'sd20;
  localparam sdiff_t BALL_R0 = 12'sd8;
  localparam sdiff_t BALL_R1 = 12'sd16;
  localparam sdiff_t BALL_R2 = 12'sd20;
  localparam sdiff_t BALL_W0 = 12'sd4;
  localparam sdiff_t BALL_W1 = 12'sd3;
  localparam sdiff_t BALL_W2 = 12'sd1;
  function automatic logic ball_hit(sdiff_t dy, sdiff_t dx);
    sdiff_t ay, ax;
    ay = dy[11] ? -dy : dy;
    ax = dx[11] ? -dx : dx;
    return (ay <= BALL_R0 && ax <= BALL_W0) ||
           (ay > BALL_R0 && ay <= BALL_R1 && ax <= BALL_W1) ||
           (ay > BALL_R1 && ay <= BALL_R2 && ax <= BALL_W2);
  endfunction
endpackage

// File: rtl/frame_render_writer_if.sv
// frame_render_writer_if: pixel write bus (wr_valid/wr_addr/wr_data from master, wr_ready from memory)
interface frame_render_writer_if #(
  parameter int ADDR_W = 18,
  parameter int COLOR_W = 6
);
  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  modport master(output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/frame_render_writer_sprite_hit.sv
// sprite_hit: platform rectangle test; row_i/col_i pixel, px_i centre column, py_i top row, pw_i half-width -> hit_o
module sprite_hit
  import frame_render_pkg::*;
(
  input  logic [9:0] row_i,
  input  logic [6:0] col_i,
  input  logic [6:0] px_i,
  input  logic [9:0] py_i,
  input  logic [5:0] pw_i,
  output logic       hit_o
);
  sdiff_t dr, dl, dh;
  always_comb begin
    dr = sdiff_t'({2'b0, row_i}) - sdiff_t'({2'b0, py_i});
    dl = sdiff_t'({5'b0, col_i}) - sdiff_t'({5'b0, px_i}) + sdiff_t'({6'b0, pw_i});
    dh = sdiff_t'({5'b0, px_i}) + sdiff_t'({6'b0, pw_i}) - sdiff_t'({5'b0, col_i});
    hit_o = !dr[11] && dr < PLAT_H && !dl[11] && !dh[11];
  end
endmodule

// File: rtl/frame_render_writer.sv
// frame_render_writer: on start latches ball/platform/over state and streams one frame of pixel writes over wr (clk, rst, start, ball_x/y, plat_x/y/w, over in; wr bus, busy, frame_done, bank out); DOUBLE_BUFFER_EN puts bank in wr_addr MSB
module frame_render_writer
  import frame_render_pkg::*;
#(
  parameter int H_COLS = 100,
  parameter int V_ROWS = 600,
  parameter int COLOR_W = 6,
  parameter int N_PLAT = 5,
  parameter int HDR_ROWS = 40,
  parameter int ADDR_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [6:0]            ball_x,
  input  logic [9:0]            ball_y,
  input  logic [7*N_PLAT-1:0]   plat_x,
  input  logic [10*N_PLAT-1:0]  plat_y,
  input  logic [6*N_PLAT-1:0]   plat_w,
  input  logic                  over,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  bank,
  frame_render_writer_if.master wr
);
`ifdef DOUBLE_BUFFER_EN
  localparam int PIX_W = ADDR_W - 1;
`else
  localparam int PIX_W = ADDR_W;
`endif
  state_t state_q, state_d;
  logic [9:0] row_q, by_q;
  logic [6:0] col_q, bx_q;
  logic [PIX_W-1:0] pix_q;
  logic [7*N_PLAT-1:0] px_q;
  logic [10*N_PLAT-1:0] py_q;
  logic [6*N_PLAT-1:0] pw_q;
  logic over_q, fire, last_col, hdr;
  logic [N_PLAT-1:0] hit;
  logic [5:0] colour;
  sdiff_t dy, dx;
  assign fire = wr.wr_valid & wr.wr_ready;
  assign last_col = col_q == 7'(H_COLS - 1);
  always_comb begin
    state_d = state_q == IDLE  ? (start ? LATCH : IDLE) :
              state_q == LATCH ? RUN :
              state_q == RUN   ? (fire && last_col && row_q == 10'(V_ROWS - 1) ? DONE : RUN) : IDLE;
    wr.wr_valid = state_q == RUN;
    busy = state_q != IDLE;
    frame_done = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      pix_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      px_q <= '0;
      py_q <= '0;
      pw_q <= '0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LATCH) begin
        bx_q <= ball_x;
        by_q <= ball_y;
        px_q <= plat_x;
        py_q <= plat_y;
        pw_q <= plat_w;
        over_q <= over;
      end
      if (state_q != RUN) begin
        row_q <= '0;
        col_q <= '0;
        pix_q <= '0;
      end else if (fire) begin
        col_q <= last_col ? '0 : col_q + 1'b1;
        row_q <= last_col ? row_q + 1'b1 : row_q;
        pix_q <= pix_q + 1'b1;
      end
    end
  end
  for (genvar i = 0; i < N_PLAT; i++) begin : g_plat
    sprite_hit u_hit (
      .row_i(row_q),
      .col_i(col_q),
      .px_i(px_q[7*i +: 7]),
      .py_i(py_q[10*i +: 10]),
      .pw_i(pw_q[6*i +: 6]),
      .hit_o(hit[i])
    );
  end
  always_comb begin
    dy = sdiff_t'({2'b0, row_q}) - sdiff_t'({2'b0, by_q});
    dx = sdiff_t'({5'b0, col_q}) - sdiff_t'({5'b0, bx_q});
    hdr = row_q < 10'(HDR_ROWS) && col_q >= 7'd5 && col_q <= 7'(H_COLS - 5);
    colour = over_q ? COL_OVER : hdr ? COL_HDR : |hit ? COL_PLAT : ball_hit(dy, dx) ? COL_BALL : COL_BG;
  end
  assign wr.wr_data = wr.wr_valid ? COLOR_W'(colour) : '0;
`ifdef DOUBLE_BUFFER_EN
  logic bank_q;
  always_ff @(posedge clk) bank_q <= rst ? 1'b0 : bank_q ^ (state_q == DONE);
  assign bank = bank_q;
  assign wr.wr_addr = {bank_q, pix_q};
`else
  assign bank = 1'b0;
  assign wr.wr_addr = pix_q;
`endif
endmodule

// File: tb/tb_frame_render_writer.sv
// tb_frame_render_writer: scoreboard bench for frame_render_writer on a full-size and a short-frame instance
module tb_frame_render_writer;
  localparam int AW = 18;
`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int PW = DB ? AW - 1 : AW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, over = 1'b0, rdy = 1'b1, sel = 1'b0;
  logic [6:0] ball_x = '0;
  logic [9:0] ball_y = '0;
  logic [34:0] plat_x = '0;
  logic [49:0] plat_y = '0;
  logic [29:0] plat_w = '0;
  logic busy_b, busy_s, done_b, done_s, bank_b, bank_s;
  frame_render_writer_if #(.ADDR_W(AW), .COLOR_W(6)) wb();
  frame_render_writer_if #(.ADDR_W(AW), .COLOR_W(6)) ws();
  assign wb.wr_ready = rdy;
  assign ws.wr_ready = rdy;
  frame_render_writer #(.ADDR_W(AW)) u_big (
    .clk(clk), .rst(rst), .start(start & ~sel), .ball_x(ball_x), .ball_y(ball_y),
    .plat_x(plat_x), .plat_y(plat_y), .plat_w(plat_w), .over(over),
    .busy(busy_b), .frame_done(done_b), .bank(bank_b), .wr(wb)
  );
  frame_render_writer #(.V_ROWS(30), .HDR_ROWS(8), .ADDR_W(AW)) u_small (
    .clk(clk), .rst(rst), .start(start & sel), .ball_x(ball_x), .ball_y(ball_y),
    .plat_x(plat_x), .plat_y(plat_y), .plat_w(plat_w), .over(over),
    .busy(busy_s), .frame_done(done_s), .bank(bank_s), .wr(ws)
  );
  always #5 clk = ~clk;
  int tests = 0, failed = 0;
  int m_px[5], m_py[5], m_pw[5];
  int m_bx, m_by, m_hdr;
  bit m_over, aborted;
  bit mbank[2];
  int sb_a[$];
  logic [5:0] sb_d[$];
  logic [5:0] cap[4];
  logic [AW-1:0] first_a;

  function automatic logic [5:0] model(int r, int c);
    int dy, dx;
    if (m_over) return 6'b000011;
    if (r < m_hdr && c >= 5 && c <= 95) return 6'b000000;
    for (int i = 0; i < 5; i++)
      if (r >= m_py[i] && r <= m_py[i] + 19 && c >= m_px[i] - m_pw[i] && c <= m_px[i] + m_pw[i]) return 6'b001100;
    dy = r - m_by;
    dx = c - m_bx;
    if (dy < 0) dy = -dy;
    if (dx < 0) dx = -dx;
    if ((dy <= 8 && dx <= 4) || (dy > 8 && dy <= 16 && dx <= 3) || (dy > 16 && dy <= 20 && dx <= 1)) return 6'b000011;
    return 6'b110100;
  endfunction

  task automatic sample(output logic v, output logic [AW-1:0] a, output logic [5:0] d, output logic dn, bz, bk);
    v = sel ? ws.wr_valid : wb.wr_valid;
    a = sel ? ws.wr_addr : wb.wr_addr;
    d = sel ? ws.wr_data : wb.wr_data;
    dn = sel ? done_s : done_b;
    bz = sel ? busy_s : busy_b;
    bk = sel ? bank_s : bank_b;
  endtask

  task automatic set_plat(input int i, input int x, input int y, input int w);
    plat_x[7*i +: 7] = 7'(x);
    plat_y[10*i +: 10] = 10'(y);
    plat_w[6*i +: 6] = 6'(w);
  endtask

  task automatic clear_plats;
    for (int i = 0; i < 5; i++) set_plat(i, 0, 1000, 0);
  endtask

  task automatic run_frame(input bit rnd, input bit mid, input int abort_at);
    int npix, base, cyc, n_wr, stalls, errs, stall_errs, busy_errs, done_cyc, fea;
    bit stalled, moved;
    logic v, dn, bz, bk;
    logic [AW-1:0] a, la, fa;
    logic [5:0] d, ld, fd, fed, ed;
    npix = (sel ? 30 : 600) * 100;
    m_hdr = sel ? 8 : 40;
    m_bx = int'(ball_x);
    m_by = int'(ball_y);
    m_over = over;
    for (int i = 0; i < 5; i++) begin
      m_px[i] = int'(plat_x[7*i +: 7]);
      m_py[i] = int'(plat_y[10*i +: 10]);
      m_pw[i] = int'(plat_w[6*i +: 6]);
    end
    base = (DB && mbank[sel]) ? (1 << (AW - 1)) : 0;
    sb_a.delete();
    sb_d.delete();
    for (int r = 0; r < npix / 100; r++)
      for (int c = 0; c < 100; c++) begin
        sb_a.push_back(base + r * 100 + c);
        sb_d.push_back(model(r, c));
      end
    n_wr = 0; stalls = 0; errs = 0; stall_errs = 0; busy_errs = 0; done_cyc = -1; fea = 0;
    stalled = 1'b0; moved = 1'b0; la = '0; ld = '0; fa = '0; fd = '0; fed = '0; first_a = '1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 4 * npix + 100) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      sample(v, a, d, dn, bz, bk);
      if (abort_at >= 0 && v && a[PW-1:0] == PW'(abort_at)) begin
        aborted = 1'b1;
        return;
      end
      if (mid && !moved && n_wr >= 500) begin
        ball_x = ball_x + 7'd20;
        ball_y = ball_y + 10'd5;
        plat_x[6:0] = plat_x[6:0] + 7'd3;
        moved = 1'b1;
      end
      if (!bz) busy_errs++;
      if (v) begin
        if (stalled && (a !== la || d !== ld)) stall_errs++;
        if (rdy) begin
          if (n_wr == 0) first_a = a;
          if (sb_a.size() == 0) errs++;
          else begin
            fea = sb_a.pop_front();
            ed = sb_d.pop_front();
            if (a !== AW'(fea) || d !== ed) begin
              if (errs == 0) begin fa = a; fd = d; fed = ed; end
              errs++;
            end
          end
          if (!sel && a[PW-1:0] == PW'(30054)) cap[0] = d;
          if (!sel && a[PW-1:0] == PW'(30055)) cap[1] = d;
          if (!sel && a[PW-1:0] == PW'(10015)) cap[2] = d;
          if (!sel && a[PW-1:0] == PW'(12020)) cap[3] = d;
          n_wr++;
        end else stalls++;
        stalled = !rdy;
        la = a;
        ld = d;
      end
      if (dn) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    tests++;
    if (n_wr !== npix) begin failed++; $display("FAIL write_count: got %0d, expected %0d", n_wr, npix); end
    tests++;
    if (done_cyc !== npix + stalls + 2) begin failed++; $display("FAIL frame_done_cycle: got %0d, expected %0d", done_cyc, npix + stalls + 2); end
    tests++;
    if (errs !== 0) begin failed++; $display("FAIL scoreboard: %0d bad writes, first got addr %0d data %b, expected data %b", errs, fa, fd, fed); end
    tests++;
    if (stall_errs !== 0) begin failed++; $display("FAIL stall_stable: got %0d changes during stalls, expected 0", stall_errs); end
    tests++;
    if (busy_errs !== 0) begin failed++; $display("FAIL busy_during_frame: got %0d low cycles, expected 0", busy_errs); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (DB) mbank[sel] = !mbank[sel];
    sample(v, a, d, dn, bz, bk);
    tests++;
    if ({bz, dn, v} !== 3'b000) begin failed++; $display("FAIL after_done: got busy/done/valid %b%b%b, expected 000", bz, dn, v); end
    tests++;
    if (bk !== mbank[sel]) begin failed++; $display("FAIL bank: got %b, expected %b", bk, mbank[sel]); end
    @(posedge clk); #1;
    sample(v, a, d, dn, bz, bk);
    tests++;
    if (bz !== 1'b0) begin failed++; $display("FAIL start_in_done_ignored: got busy %b, expected 0", bz); end
  endtask

  task automatic test_reset;
    logic v, dn, bz, bk;
    logic [AW-1:0] a;
    logic [5:0] d;
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      sample(v, a, d, dn, bz, bk);
      tests++;
      if ({v, bz, dn, bk} !== 4'b0000) begin failed++; $display("FAIL reset_ctrl[%0d]: got valid/busy/done/bank %b%b%b%b, expected 0000", s, v, bz, dn, bk); end
      tests++;
      if (a !== '0 || d !== '0) begin failed++; $display("FAIL reset_bus[%0d]: got addr %0d data %b, expected 0 and 000000", s, a, d); end
    end
    start = 1'b0;
    rst = 1'b0;
    sel = 1'b0;
    mbank[0] = 1'b0;
    mbank[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame;
    sel = 1'b0;
    over = 1'b0;
    ball_x = 7'd50;
    ball_y = 10'd300;
    clear_plats();
    set_plat(0, 20, 100, 5);
    for (int k = 0; k < 4; k++) cap[k] = 'x;
    run_frame(1'b0, 1'b0, -1);
    tests++;
    if (cap[0] !== 6'b000011) begin failed++; $display("FAIL ball_edge_30054: got %b, expected 000011", cap[0]); end
    tests++;
    if (cap[1] !== 6'b110100) begin failed++; $display("FAIL ball_out_30055: got %b, expected 110100", cap[1]); end
    tests++;
    if (cap[2] !== 6'b001100) begin failed++; $display("FAIL plat_edge_10015: got %b, expected 001100", cap[2]); end
    tests++;
    if (cap[3] !== 6'b110100) begin failed++; $display("FAIL plat_below_12020: got %b, expected 110100", cap[3]); end
  endtask

  task automatic test_stall;
    sel = 1'b1;
    ball_x = 7'd2;
    ball_y = 10'd12;
    clear_plats();
    set_plat(0, 1, 2, 5);
    set_plat(1, 98, 15, 5);
    set_plat(2, 50, 25, 10);
    run_frame(1'b1, 1'b0, -1);
  endtask

  task automatic test_mid_change;
    sel = 1'b1;
    ball_x = 7'd60;
    ball_y = 10'd18;
    clear_plats();
    set_plat(0, 30, 10, 8);
    run_frame(1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid;
    logic v, dn, bz, bk;
    logic [AW-1:0] a;
    logic [5:0] d;
    sel = 1'b1;
    aborted = 1'b0;
    ball_x = 7'd40;
    ball_y = 10'd15;
    clear_plats();
    set_plat(0, 70, 5, 6);
    run_frame(1'b0, 1'b0, 1234);
    tests++;
    if (aborted !== 1'b1) begin failed++; $display("FAIL reach_pixel_1234: got %b, expected 1", aborted); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mbank[0] = 1'b0;
    mbank[1] = 1'b0;
    sample(v, a, d, dn, bz, bk);
    tests++;
    if ({v, bz, dn, bk} !== 4'b0000) begin failed++; $display("FAIL midreset_ctrl: got valid/busy/done/bank %b%b%b%b, expected 0000", v, bz, dn, bk); end
    tests++;
    if (a !== '0 || d !== '0) begin failed++; $display("FAIL midreset_bus: got addr %0d data %b, expected 0 and 000000", a, d); end
    @(posedge clk); #1;
    run_frame(1'b0, 1'b0, -1);
    tests++;
    if (first_a !== '0) begin failed++; $display("FAIL restart_addr: got %0d, expected 0", first_a); end
  endtask

  task automatic test_double_buffer;
    sel = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mbank[0] = 1'b0;
    mbank[1] = 1'b0;
    over = 1'b0;
    run_frame(1'b0, 1'b0, -1);
    tests++;
    if (first_a[AW-1] !== 1'b0) begin failed++; $display("FAIL frame1_msb: got %b, expected 0", first_a[AW-1]); end
    over = 1'b1;
    run_frame(1'b0, 1'b0, -1);
    tests++;
    if (first_a[AW-1] !== DB) begin failed++; $display("FAIL frame2_msb: got %b, expected %b", first_a[AW-1], DB); end
    over = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_full_frame();
    test_stall();
    test_mid_change();
    test_reset_mid();
    test_double_buffer();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
